// File: rtl/fp_vector_checker.sv
// fp_vector_checker: streams {a, b, expected} vectors from a synchronous-read
// vector memory into an arithmetic DUT and checks each result against the
// expected value, which is delayed to line up with the DUT pipeline. It keeps
// pass/fail counters and captures the first mismatch.
// Optional feature macro: FPV_NAN_EQUIV_EN. When it is defined, any NaN result
// matches any NaN expected value. Otherwise results are compared bit-exactly.
module fp_vector_checker #(
  parameter int DATA_W       = 16,
  parameter int EXP_W        = 8,
  parameter int N_TESTS      = 10000,
  parameter int ADDR_W       = 14,
  parameter int DUT_LAT      = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                vec_rd_en,
  output logic [ADDR_W-1:0]   vec_addr,
  input  logic [3*DATA_W-1:0] vec_data,
  output logic [DATA_W-1:0]   a_operand,
  output logic [DATA_W-1:0]   b_operand,
  output logic                op_valid,
  input  logic [DATA_W-1:0]   dut_result,
  output logic                busy,
  output logic                done,
  output logic [31:0]         pass_cnt,
  output logic [31:0]         fail_cnt,
  output logic [ADDR_W-1:0]   first_fail_idx,
  output logic [DATA_W-1:0]   first_fail_got,
  output logic [DATA_W-1:0]   first_fail_exp
);
  localparam int                MAN_W    = DATA_W - 1 - EXP_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TESTS - 1);
  localparam logic [ADDR_W-1:0] NO_FAIL  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         pass_q, pass_d;
  logic [31:0]         fail_q, fail_d;
  logic                ff_seen_q, ff_seen_d;
  logic [ADDR_W-1:0]   ffi_q, ffi_d;
  logic [DATA_W-1:0]   ffg_q, ffg_d;
  logic [DATA_W-1:0]   ffe_q, ffe_d;

  // Memory-return stage: a read was issued last cycle, plus the index it carried.
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;

  // Operand registers and the expected/index delay line. Stage 0 sits next to
  // the operands, and stage DUT_LAT lines up with dut_result.
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DUT_LAT:0]    pv_q, pv_d;
  logic [DATA_W-1:0]   pe_q [0:DUT_LAT];
  logic [DATA_W-1:0]   pe_d [0:DUT_LAT];
  logic [ADDR_W-1:0]   pi_q [0:DUT_LAT];
  logic [ADDR_W-1:0]   pi_d [0:DUT_LAT];

  logic cmp_valid, cmp_match, mismatch, stop_now, in_flight;

  // NaN test: exponent field all-ones and mantissa non-zero.
  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (&x[DATA_W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  assign vec_rd_en      = (state_q == S_RUN);
  assign vec_addr       = addr_q;
  assign a_operand      = a_q;
  assign b_operand      = b_q;
  assign op_valid       = pv_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_got = ffg_q;
  assign first_fail_exp = ffe_q;

  // Compare the DUT result with the expected value at the end of the delay line.
  always_comb begin
    cmp_valid = pv_q[DUT_LAT];
`ifdef FPV_NAN_EQUIV_EN
    cmp_match = (dut_result == pe_q[DUT_LAT]) ||
                (is_nan(dut_result) && is_nan(pe_q[DUT_LAT]));
`else
    cmp_match = (dut_result == pe_q[DUT_LAT]);
`endif
    mismatch  = cmp_valid && !cmp_match;
    stop_now  = (STOP_ON_FAIL != 0) && mismatch;
    in_flight = rd_valid_q || (|pv_q);
  end

  // Advance the vector pipeline. A stop drops the read still in flight from memory.
  always_comb begin
    rd_valid_d = vec_rd_en && !stop_now;
    rd_idx_d   = addr_q;
    pv_d[0]    = rd_valid_q && !stop_now;
    pe_d[0]    = vec_data[DATA_W-1:0];
    pi_d[0]    = rd_idx_q;
    for (int k = 1; k <= DUT_LAT; k++) begin
      pv_d[k] = pv_q[k-1];
      pe_d[k] = pe_q[k-1];
      pi_d[k] = pi_q[k-1];
    end
    a_d = pv_d[0] ? vec_data[3*DATA_W-1 -: DATA_W] : a_q;
    b_d = pv_d[0] ? vec_data[2*DATA_W-1 -: DATA_W] : b_q;
  end

  // Next state for the run FSM, the counters and the first-failure capture.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_seen_d = ff_seen_q;
    ffi_d     = ffi_q;
    ffg_d     = ffg_q;
    ffe_d     = ffe_q;

    if (cmp_valid) begin
      if (cmp_match) begin
        pass_d = pass_q + 32'd1;
      end else begin
        fail_d = fail_q + 32'd1;
        if (!ff_seen_q) begin
          ff_seen_d = 1'b1;
          ffi_d     = pi_q[DUT_LAT];
          ffg_d     = dut_result;
          ffe_d     = pe_q[DUT_LAT];
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          addr_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = '0;
          fail_d    = '0;
          ff_seen_d = 1'b0;
          ffi_d     = NO_FAIL;
          ffg_d     = '0;
          ffe_d     = '0;
        end
      end
      S_RUN: begin
        if (stop_now || addr_q == LAST_IDX) state_d = S_DRAIN;
        else                                addr_d  = addr_q + 1'b1;
      end
      S_DRAIN: begin
        if (!in_flight) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, counters, capture and operand registers, with synchronous reset to idle.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_seen_q  <= 1'b0;
      ffi_q      <= NO_FAIL;
      ffg_q      <= '0;
      ffe_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pv_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_seen_q  <= ff_seen_d;
      ffi_q      <= ffi_d;
      ffg_q      <= ffg_d;
      ffe_q      <= ffe_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pv_q       <= pv_d;
    end
  end

  // Delay-line payload for the expected value and the index.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are not reset; pv_q qualifies every stage, so stale contents are never used.
    pe_q <= pe_d;
    pi_q <= pi_d;
  end
endmodule

// File: tb/tb_fp_vector_checker.sv
// tb_fp_vector_checker: three checker instances (combinational, 3-stage and
// stop-on-fail 2-stage DUTs) fed from bench-side vector memories. The DUT
// stand-in is a truncating BF16 multiplier. A run-level reference model
// predicts the counters, the first-failure capture and the completion cycle.
module tb_fp_vector_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bf16_mul(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p;
    logic [6:0]  m;
    int          e;
    if (x[14:7] == 8'hFF && x[6:0] != 7'd0) return x;
    if (y[14:7] == 8'hFF && y[6:0] != 7'd0) return y;
    if (x[14:7] == 8'h00 || y[14:7] == 8'h00) return {x[15] ^ y[15], 15'h0};
    p = {8'h0, 1'b1, x[6:0]} * {8'h0, 1'b1, y[6:0]};
    e = int'(x[14:7]) + int'(y[14:7]) - 127;
    if (p[15]) begin m = p[14:8]; e = e + 1; end
    else       m = p[13:7];
    return {x[15] ^ y[15], 8'(e), m};
  endfunction

  function automatic bit nan16(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic bit fp_match(input logic [15:0] r, input logic [15:0] e);
`ifdef FPV_NAN_EQUIV_EN
    return (r == e) || (nan16(r) && nan16(e));
`else
    return r == e;
`endif
  endfunction

  // Instance A: N=4, combinational DUT
  logic        start_a = 1'b0, rd_a, opv_a, busy_a, done_a;
  logic [13:0] addr_a, ffi_a;
  logic [47:0] vd_a;
  logic [15:0] aop_a, bop_a, res_a, ffg_a, ffe_a;
  logic [31:0] pass_a, fail_a;
  // Instance B: N=8, DUT_LAT=3
  logic        start_b = 1'b0, rd_b, opv_b, busy_b, done_b;
  logic [13:0] addr_b, ffi_b;
  logic [47:0] vd_b;
  logic [15:0] aop_b, bop_b, res_b, ffg_b, ffe_b;
  logic [31:0] pass_b, fail_b;
  // Instance C: N=16, DUT_LAT=2, STOP_ON_FAIL=1
  logic        start_c = 1'b0, rd_c, opv_c, busy_c, done_c;
  logic [13:0] addr_c, ffi_c;
  logic [47:0] vd_c;
  logic [15:0] aop_c, bop_c, res_c, ffg_c, ffe_c;
  logic [31:0] pass_c, fail_c;

  fp_vector_checker #(.N_TESTS(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_rd_en(rd_a), .vec_addr(addr_a),
    .vec_data(vd_a), .a_operand(aop_a), .b_operand(bop_a), .op_valid(opv_a),
    .dut_result(res_a), .busy(busy_a), .done(done_a), .pass_cnt(pass_a),
    .fail_cnt(fail_a), .first_fail_idx(ffi_a), .first_fail_got(ffg_a), .first_fail_exp(ffe_a));

  fp_vector_checker #(.N_TESTS(8), .DUT_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_rd_en(rd_b), .vec_addr(addr_b),
    .vec_data(vd_b), .a_operand(aop_b), .b_operand(bop_b), .op_valid(opv_b),
    .dut_result(res_b), .busy(busy_b), .done(done_b), .pass_cnt(pass_b),
    .fail_cnt(fail_b), .first_fail_idx(ffi_b), .first_fail_got(ffg_b), .first_fail_exp(ffe_b));

  fp_vector_checker #(.N_TESTS(16), .DUT_LAT(2), .STOP_ON_FAIL(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .vec_rd_en(rd_c), .vec_addr(addr_c),
    .vec_data(vd_c), .a_operand(aop_c), .b_operand(bop_c), .op_valid(opv_c),
    .dut_result(res_c), .busy(busy_c), .done(done_c), .pass_cnt(pass_c),
    .fail_cnt(fail_c), .first_fail_idx(ffi_c), .first_fail_got(ffg_c), .first_fail_exp(ffe_c));

  // Synchronous-read vector memories and DUT stand-ins
  logic [47:0] mem_a [0:15];
  logic [47:0] mem_b [0:15];
  logic [47:0] mem_c [0:15];
  logic [15:0] pipe_b [0:2];
  logic [15:0] pipe_c [0:1];

  always @(posedge clk) begin
    if (rd_a) vd_a <= mem_a[addr_a[3:0]];
    if (rd_b) vd_b <= mem_b[addr_b[3:0]];
    if (rd_c) vd_c <= mem_c[addr_c[3:0]];
    pipe_b[0] <= bf16_mul(aop_b, bop_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_c[0] <= bf16_mul(aop_c, bop_c);
    pipe_c[1] <= pipe_c[0];
  end
  assign res_a = bf16_mul(aop_a, bop_a);
  assign res_b = pipe_b[2];
  assign res_c = pipe_c[1];

  // Reference model state
  logic [47:0] cur [0:15];
  int          m_pass, m_fail;
  logic [13:0] m_idx;
  logic [15:0] m_got, m_exp;

  // Run-level model: vectors are checked in order; with stop-on-fail, the vectors
  // already inside the DUT pipeline (the next `lat`) are still checked.
  task automatic model(input int n, input int lat, input bit stop);
    int limit;
    logic [15:0] r, e;
    m_pass = 0; m_fail = 0; m_idx = 14'h3FFF; m_got = '0; m_exp = '0; limit = n;
    for (int i = 0; i < n; i++) begin
      if (i < limit) begin
        r = bf16_mul(cur[i][47:32], cur[i][31:16]);
        e = cur[i][15:0];
        if (fp_match(r, e)) m_pass++;
        else begin
          m_fail++;
          if (m_fail == 1) begin
            m_idx = 14'(i); m_got = r; m_exp = e;
            if (stop) limit = (i + 1 + lat < n) ? i + 1 + lat : n;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 7'($urandom_range(0, 127))};
  endfunction

  task automatic fill_random(input int n, input int bad_pct, input bit nan_ok);
    logic [15:0] a, b, e;
    for (int i = 0; i < n; i++) begin
      a = rand_op(); b = rand_op();
      if (nan_ok && $urandom_range(0, 3) == 0) a = {1'b0, 8'hFF, 7'($urandom_range(1, 127))};
      e = bf16_mul(a, b);
      if (int'($urandom_range(0, 99)) < bad_pct) e = e ^ (16'd1 << $urandom_range(0, 15));
      cur[i] = {a, b, e};
    end
  endtask

  task automatic set_fixed();
    cur[0] = {16'h3F80, 16'h4000, 16'h4000};
    cur[1] = {16'h4040, 16'h4040, 16'h4110};
    cur[2] = {16'h0000, 16'h4000, 16'h0000};
    cur[3] = {16'hBF80, 16'h3F80, 16'hBF80};
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin mem_a[i] = cur[i]; mem_b[i] = cur[i]; mem_c[i] = cur[i]; end
  endtask

  // Pulse start; return the first cycle (relative to the start cycle) with done=1, busy=0.
  task automatic run_a(output int done_rel, output logic [13:0] addr1);
    int c0;
    @(posedge clk); #1; start_a = 1'b1; c0 = cyc;
    @(posedge clk); #1; start_a = 1'b0;
    addr1 = addr_a; done_rel = -1;
    for (int k = 0; k < 200 && done_rel < 0; k++) begin
      if (done_a && !busy_a) done_rel = cyc - c0;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (done_rel < 0) begin errors++; $display("FAIL run_a_timeout no done within 200 cycles"); end
  endtask

  task automatic run_b(input int restart_at, output int done_rel,
                       output logic [31:0] ov_mask, output logic [31:0] busy_mask);
    int c0, rel;
    ov_mask = '0; busy_mask = '0;
    @(posedge clk); #1; start_b = 1'b1; c0 = cyc;
    @(posedge clk); #1; start_b = 1'b0;
    done_rel = -1;
    for (int k = 0; k < 200 && done_rel < 0; k++) begin
      rel = cyc - c0;
      if (rel < 32) begin ov_mask[rel] = opv_b; busy_mask[rel] = busy_b; end
      if (done_b && !busy_b) done_rel = rel;
      else begin
        start_b = (rel == restart_at);
        @(posedge clk); #1;
      end
    end
    start_b = 1'b0;
    checks++;
    if (done_rel < 0) begin errors++; $display("FAIL run_b_timeout no done within 200 cycles"); end
  endtask

  task automatic run_c(output int done_rel);
    int c0;
    @(posedge clk); #1; start_c = 1'b1; c0 = cyc;
    @(posedge clk); #1; start_c = 1'b0;
    done_rel = -1;
    for (int k = 0; k < 200 && done_rel < 0; k++) begin
      if (done_c && !busy_c) done_rel = cyc - c0;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (done_rel < 0) begin errors++; $display("FAIL run_c_timeout no done within 200 cycles"); end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, rd_a, opv_a, addr_a, aop_a, bop_a, pass_a, fail_a, ffg_a, ffe_a} !== '0) begin
      errors++;
      $display("FAIL reset_zero got busy=%b done=%b rd=%b opv=%b addr=%h a=%h b=%h pass=%0d fail=%0d got=%h exp=%h want all 0",
               busy_a, done_a, rd_a, opv_a, addr_a, aop_a, bop_a, pass_a, fail_a, ffg_a, ffe_a);
    end
    checks++;
    if ({ffi_a, ffi_b, ffi_c} !== {3{14'h3FFF}}) begin
      errors++; $display("FAIL reset_ffi got %h %h %h want 3fff", ffi_a, ffi_b, ffi_c);
    end
    checks++;
    if ({busy_b, done_b, busy_c, done_c, pass_b, fail_c} !== '0) begin
      errors++; $display("FAIL reset_others got busy_b=%b done_b=%b busy_c=%b done_c=%b want 0", busy_b, done_b, busy_c, done_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d; logic [13:0] a1;
    set_fixed(); load_all();
    run_a(d, a1);
    checks++;
    if (a1 !== 14'd0) begin errors++; $display("FAIL basic_first_addr got %h want 0", a1); end
    checks++;
    if (d != 8) begin errors++; $display("FAIL basic_done_cycle got %0d want 8", d); end
    checks++;
    if (pass_a !== 32'd4 || fail_a !== 32'd0 || ffi_a !== 14'h3FFF) begin
      errors++; $display("FAIL basic_counters got pass=%0d fail=%0d idx=%h want 4 0 3fff", pass_a, fail_a, ffi_a);
    end
  endtask

  task automatic test_done_hold();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== 32'd4) begin
      errors++; $display("FAIL done_hold got done=%b busy=%b pass=%0d want 1 0 4", done_a, busy_a, pass_a);
    end
  endtask

  task automatic test_corrupt();
    int d; logic [13:0] a1;
    set_fixed(); cur[2][15:0] = 16'h0001; load_all();
    run_a(d, a1);
    checks++;
    if (pass_a !== 32'd3 || fail_a !== 32'd1 || ffi_a !== 14'd2 || ffg_a !== 16'h0000 || ffe_a !== 16'h0001) begin
      errors++;
      $display("FAIL corrupt_capture got pass=%0d fail=%0d idx=%h got=%h exp=%h want 3 1 0002 0000 0001",
               pass_a, fail_a, ffi_a, ffg_a, ffe_a);
    end
  endtask

  task automatic test_nan();
    int d; logic [13:0] a1;
    set_fixed(); cur[0] = {16'h7FC1, 16'h3F80, 16'h7FC0}; load_all();
    run_a(d, a1);
    checks++;
`ifdef FPV_NAN_EQUIV_EN
    if (pass_a !== 32'd4 || fail_a !== 32'd0 || ffi_a !== 14'h3FFF) begin
      errors++; $display("FAIL nan_equiv got pass=%0d fail=%0d idx=%h want 4 0 3fff", pass_a, fail_a, ffi_a);
    end
`else
    if (pass_a !== 32'd3 || fail_a !== 32'd1 || ffi_a !== 14'd0 || ffg_a !== 16'h7FC1 || ffe_a !== 16'h7FC0) begin
      errors++;
      $display("FAIL nan_bitwise got pass=%0d fail=%0d idx=%h got=%h exp=%h want 3 1 0000 7fc1 7fc0",
               pass_a, fail_a, ffi_a, ffg_a, ffe_a);
    end
`endif
  endtask

  task automatic test_pipelined();
    int d; logic [31:0] ov, bm;
    fill_random(8, 0, 1'b0); load_all();
    run_b(-1, d, ov, bm);
    checks++;
    if (d != 15) begin errors++; $display("FAIL pipe_done_cycle got %0d want 15", d); end
    checks++;
    if (ov !== 32'h0000_07F8) begin errors++; $display("FAIL pipe_op_valid_cycles got %h want 000007f8", ov); end
    checks++;
    if (bm !== 32'h0000_7FFE) begin errors++; $display("FAIL pipe_busy_cycles got %h want 00007ffe", bm); end
    checks++;
    if (pass_b !== 32'd8 || fail_b !== 32'd0) begin
      errors++; $display("FAIL pipe_counters got pass=%0d fail=%0d want 8 0", pass_b, fail_b);
    end
  endtask

  task automatic test_back_to_back();
    int d; logic [31:0] ov, bm;
    fill_random(8, 30, 1'b0); load_all(); model(8, 3, 1'b0);
    run_b(5, d, ov, bm);
    checks++;
    if (d != 15) begin errors++; $display("FAIL restart_ignored_done got %0d want 15", d); end
    checks++;
    if (pass_b !== 32'(m_pass) || fail_b !== 32'(m_fail) || ffi_b !== m_idx || ffg_b !== m_got || ffe_b !== m_exp) begin
      errors++;
      $display("FAIL restart_ignored_counters got %0d/%0d %h %h %h want %0d/%0d %h %h %h",
               pass_b, fail_b, ffi_b, ffg_b, ffe_b, m_pass, m_fail, m_idx, m_got, m_exp);
    end
  endtask

  task automatic test_stop_on_fail();
    int d;
    fill_random(16, 0, 1'b0); cur[5][15:0] = cur[5][15:0] ^ 16'h0100; load_all();
    run_c(d);
    checks++;
    if (pass_c !== 32'd7 || fail_c !== 32'd1 || ffi_c !== 14'd5) begin
      errors++; $display("FAIL stop_counts got pass=%0d fail=%0d idx=%h want 7 1 0005", pass_c, fail_c, ffi_c);
    end
    checks++;
    if (d != 14) begin errors++; $display("FAIL stop_done_cycle got %0d want 14", d); end
  endtask

  task automatic test_reset_midrun();
    int c0, d; logic [13:0] a1;
    set_fixed(); cur[0][15:0] = 16'h4001; load_all(); model(4, 0, 1'b0);
    @(posedge clk); #1; start_a = 1'b1; c0 = cyc;
    @(posedge clk); #1; start_a = 1'b0;
    while (cyc - c0 < 6) begin @(posedge clk); #1; end
    checks++;
    if (fail_a !== 32'd1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL midrun_before_reset got fail=%0d busy=%b want 1 1", fail_a, busy_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (pass_a !== 32'd0 || fail_a !== 32'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || opv_a !== 1'b0 || ffi_a !== 14'h3FFF) begin
      errors++;
      $display("FAIL midrun_reset got pass=%0d fail=%0d busy=%b done=%b opv=%b idx=%h want 0 0 0 0 0 3fff",
               pass_a, fail_a, busy_a, done_a, opv_a, ffi_a);
    end
    run_a(d, a1);
    checks++;
    if (a1 !== 14'd0 || d != 8) begin errors++; $display("FAIL replay_timing got addr=%h done=%0d want 0 8", a1, d); end
    checks++;
    if (pass_a !== 32'(m_pass) || fail_a !== 32'(m_fail) || ffi_a !== m_idx || ffg_a !== m_got || ffe_a !== m_exp) begin
      errors++;
      $display("FAIL replay_counters got %0d/%0d %h %h %h want %0d/%0d %h %h %h",
               pass_a, fail_a, ffi_a, ffg_a, ffe_a, m_pass, m_fail, m_idx, m_got, m_exp);
    end
  endtask

  task automatic test_start_in_reset();
    bit seen_busy;
    @(posedge clk); #1;
    rst = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_a = 1'b0;
    seen_busy = busy_a || rd_a;
    repeat (3) begin @(posedge clk); #1; seen_busy = seen_busy || busy_a || rd_a; end
    checks++;
    if (seen_busy) begin errors++; $display("FAIL start_in_reset got busy=1 want 0"); end
  endtask

  task automatic test_random();
    int d; logic [13:0] a1; logic [31:0] ov, bm;
    for (int r = 0; r < 6; r++) begin
      fill_random(4, 30, 1'b1); load_all(); model(4, 0, 1'b0);
      run_a(d, a1);
      checks++;
      if (pass_a !== 32'(m_pass) || fail_a !== 32'(m_fail) || ffi_a !== m_idx || ffg_a !== m_got || ffe_a !== m_exp || d != 8) begin
        errors++;
        $display("FAIL rand_a[%0d] got %0d/%0d %h %h %h d=%0d want %0d/%0d %h %h %h d=8",
                 r, pass_a, fail_a, ffi_a, ffg_a, ffe_a, d, m_pass, m_fail, m_idx, m_got, m_exp);
      end
    end
    for (int r = 0; r < 6; r++) begin
      fill_random(8, 25, 1'b1); load_all(); model(8, 3, 1'b0);
      run_b(-1, d, ov, bm);
      checks++;
      if (pass_b !== 32'(m_pass) || fail_b !== 32'(m_fail) || ffi_b !== m_idx || ffg_b !== m_got || ffe_b !== m_exp || d != 15) begin
        errors++;
        $display("FAIL rand_b[%0d] got %0d/%0d %h %h %h d=%0d want %0d/%0d %h %h %h d=15",
                 r, pass_b, fail_b, ffi_b, ffg_b, ffe_b, d, m_pass, m_fail, m_idx, m_got, m_exp);
      end
    end
    for (int r = 0; r < 8; r++) begin
      fill_random(16, 10, 1'b0); load_all(); model(16, 2, 1'b1);
      run_c(d);
      checks++;
      if (pass_c !== 32'(m_pass) || fail_c !== 32'(m_fail) || ffi_c !== m_idx || ffg_c !== m_got || ffe_c !== m_exp
          || d != m_pass + m_fail + 6) begin
        errors++;
        $display("FAIL rand_c[%0d] got %0d/%0d %h %h %h d=%0d want %0d/%0d %h %h %h d=%0d",
                 r, pass_c, fail_c, ffi_c, ffg_c, ffe_c, d, m_pass, m_fail, m_idx, m_got, m_exp, m_pass + m_fail + 6);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cur[i] = '0;
    load_all();
    test_reset();
    test_basic();
    test_done_hold();
    test_corrupt();
    test_nan();
    test_pipelined();
    test_back_to_back();
    test_stop_on_fail();
    test_reset_midrun();
    test_start_in_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_vector_checker.md
# fp_vector_checker

Synthesizable, parametrised self-checking vector engine for floating-point arithmetic units (BF16mul and wider successors). It streams `{a, b, expected}` vectors from a synchronous-read vector memory into a DUT with configurable pipeline latency, compares each DUT result against the delayed expected value, and keeps pass/fail counts plus first-failure capture. It sits beside the arithmetic block on FPGA for on-silicon regression.

## Interface
- `DATA_W`, 16: operand/result width.
- `EXP_W`, 8: exponent field width; mantissa width is `DATA_W-1-EXP_W`.
- `N_TESTS`, 10000: vectors per run, ≥1.
- `ADDR_W`, 14: vector memory address width; `2**ADDR_W ≥ N_TESTS`.
- `DUT_LAT`, 0: DUT cycles from operand to result; 0 = combinational DUT.
- `STOP_ON_FAIL`, 0: 1 = end the run at the first mismatch.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle run request.
- `vec_rd_en`  out  1  vector memory read strobe.
- `vec_addr`  out  ADDR_W  vector index.
- `vec_data`  in  3*DATA_W  `{a, b, expected}`, valid the cycle after `vec_rd_en`.
- `a_operand`, `b_operand`  out  DATA_W  registered DUT operands.
- `op_valid`  out  1  operands hold a live vector.
- `dut_result`  in  DATA_W  DUT output.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until next start or reset.
- `pass_cnt`, `fail_cnt`  out  32  comparison counters.
- `first_fail_idx`  out  ADDR_W  index of first mismatch; all-ones if none.
- `first_fail_got`, `first_fail_exp`  out  DATA_W  captured result/expected of first mismatch.

## Operation
- FSM: IDLE → RUN on `start`; RUN → DRAIN after issuing index `N_TESTS-1` (or immediately on first fail if `STOP_ON_FAIL`); DRAIN → DONE once the last in-flight vector is compared; DONE → RUN on `start` (counters and capture cleared).
- RUN: `vec_rd_en`=1, `vec_addr` increments by 1 per cycle from 0; no wrap, stops at `N_TESTS-1`.
- Returned `vec_data` is registered into `a_operand`/`b_operand`; `expected` enters a `DUT_LAT`-deep delay line alongside a valid bit and the index.
- Compare at the sample stage: match if `dut_result == expected` exactly; match → `pass_cnt`+1, else `fail_cnt`+1; first mismatch loads the three capture registers, later mismatches do not.
- With `STOP_ON_FAIL`: issuing stops the cycle the first mismatch is detected; vectors already in flight are still compared and counted.
- `start` while `busy` is ignored. `start` while `rst` is high is ignored.
- Reset (any state, including mid-run): IDLE; all outputs 0 except `first_fail_idx` = all-ones; in-flight vectors discarded, counters cleared.

## Timing
- `start` sampled at edge of cycle 0; `busy`=1 and `vec_addr`=0 in cycle 1.
- Vector i: address in cycle 1+i, data cycle 2+i, operands/`op_valid` cycle 3+i, result sampled cycle 3+i+`DUT_LAT`, counters updated visible cycle 4+i+`DUT_LAT`.
- `done`=1, `busy`=0 from cycle `N_TESTS`+4+`DUT_LAT`; counters final in that same cycle; `pass_cnt`+`fail_cnt` = vectors issued.
- Throughput: one vector per cycle, no bubbles.

## Configuration
- `FPV_NAN_EQUIV_EN` defined: a result whose exponent is all-ones and mantissa non-zero matches any expected value that is also NaN (any sign/payload); all other values still compare bit-exactly.
- Undefined: pure bitwise comparison, NaN payload differences count as failures.

## Test plan
- Defaults, N_TESTS=4, combinational correct BF16 multiplier, vectors `3F80*4000=4000`, `4040*4040=4110`, `0000*4000=0000`, `BF80*3F80=BF80` → `pass_cnt`=4, `fail_cnt`=0, `first_fail_idx`=3FFF, `done` in cycle 8.
- Same set with expected of vector 2 corrupted to `0001` → `fail_cnt`=1, `first_fail_idx`=2, `first_fail_got`=0000, `first_fail_exp`=0001.
- DUT_LAT=3 pipelined DUT, N_TESTS=8 → 8 passes, `done` cycle 15, `op_valid` high cycles 3–10.
- STOP_ON_FAIL=1, DUT_LAT=2, mismatch at index 5 of 16 → issuing stops, in-flight vectors 6–7 still counted, `pass_cnt`+`fail_cnt`=8.
- `rst` pulsed in cycle 6 of a run → next cycle all counters 0, `busy`=0, `first_fail_idx` all-ones; new `start` replays from index 0.
- Result `7FC1` vs expected `7FC0`: `fail_cnt`=1 without `FPV_NAN_EQUIV_EN`, `pass_cnt`=1 with it.
